piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter: accepts a BITS-wide word through a valid/ready handshake and shifts it out one bit per clock on SO.
- Producer end of the serial bit streams consumed by the team's serial shift registers and deserializers; SO drives their serial data input directly.
- Supports gap-free back-to-back words; a word-done strobe lets upstream logic count frames.

---
 rtl/piso_serializer.sv | 99 +++++++++
 tb/tb_piso_serializer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : piso_serializer
//  Brief    : Parallel-in serial-out transmitter. Accepts a BITS-wide word
//             through a LOAD/READY handshake and shifts it out one bit per
//             clock on SO, with gap-free back-to-back words and a DONE strobe
//             on the last bit of each word.
//  Revision : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int BITS      = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,       // asynchronous, active-low
  input  logic [BITS-1:0] PD,
  input  logic            LOAD,
  output logic            READY,
  output logic            SO,
  output logic            SO_VALID,
  output logic            DONE
);

  localparam int CW = (BITS > 2) ? $clog2(BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BITS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [BITS-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [BITS-1:0]   shifted_w;
  logic              so_w;
  logic              last_w;
  logic              accept_w;

  // Bit order only changes which end of the shift register feeds SO and
  // which way the word moves toward it; the vacated end is zero-filled.
  if (MSB_FIRST) begin : g_msb_first
    assign shifted_w = {shreg_q[BITS-2:0], 1'b0};
    assign so_w      = shreg_q[BITS-1];
  end else begin : g_lsb_first
    assign shifted_w = {1'b0, shreg_q[BITS-1:1]};
    assign so_w      = shreg_q[0];
  end

  // The last bit of a frame reopens the handshake so the next word can
  // follow without a gap cycle. The counter is held at 0 in IDLE, so the
  // last-bit decode is only meaningful in SHIFT.
  assign last_w   = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign READY    = RST && ((state_q == IDLE) || last_w);
  assign DONE     = RST && last_w;
  assign accept_w = LOAD && READY;

  // SO and SO_VALID come straight from flops; the shift register is cleared
  // whenever the block drops back to IDLE so SO idles low.
  assign SO       = so_w;
  assign SO_VALID = (state_q == SHIFT);

  // Next-state logic: load on accept, otherwise shift or retire the frame.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept_w) begin
      state_d = SHIFT;
      shreg_d = PD;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      if (last_w) begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = shifted_w;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // State, shift register and bit counter; reset aborts any frame at once.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_piso_serializer
//  Brief    : Directed self-checking bench for piso_serializer. Three
//             instances: BITS=4 LSB-first, BITS=4 MSB-first, BITS=8 LSB-first.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: BITS=4, LSB first
  logic       a_rst, a_load, a_ready, a_so, a_sov, a_done;
  logic [3:0] a_pd;
  // Instance B: BITS=4, MSB first
  logic       b_rst, b_load, b_ready, b_so, b_sov, b_done;
  logic [3:0] b_pd;
  // Instance C: BITS=8, LSB first
  logic       c_rst, c_load, c_ready, c_so, c_sov, c_done;
  logic [7:0] c_pd;

  piso_serializer #(.BITS(4), .MSB_FIRST(1'b0)) u_a (
    .CLK(clk), .RST(a_rst), .PD(a_pd), .LOAD(a_load),
    .READY(a_ready), .SO(a_so), .SO_VALID(a_sov), .DONE(a_done)
  );

  piso_serializer #(.BITS(4), .MSB_FIRST(1'b1)) u_b (
    .CLK(clk), .RST(b_rst), .PD(b_pd), .LOAD(b_load),
    .READY(b_ready), .SO(b_so), .SO_VALID(b_sov), .DONE(b_done)
  );

  piso_serializer #(.BITS(8), .MSB_FIRST(1'b0)) u_c (
    .CLK(clk), .RST(c_rst), .PD(c_pd), .LOAD(c_load),
    .READY(c_ready), .SO(c_so), .SO_VALID(c_sov), .DONE(c_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", a_ready); end
    checks++; if (a_done  !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
    checks++; if (a_so    !== 1'b0) begin errors++; $display("FAIL reset_so got %b exp 0", a_so); end
    checks++; if (a_sov   !== 1'b0) begin errors++; $display("FAIL reset_sov got %b exp 0", a_sov); end
    checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL reset_c_ready got %b exp 0", c_ready); end
    tick;
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL release_b_ready got %b exp 1", b_ready); end
    checks++; if (a_sov   !== 1'b0) begin errors++; $display("FAIL release_sov got %b exp 0", a_sov); end
    tick;
  endtask

  task automatic test_single_lsb;
    logic [3:0] exp_bits;
    exp_bits = 4'b1011;               // on SO: 1,1,0,1
    a_pd = 4'b1011; a_load = 1'b1;
    tick;
    a_load = 1'b0; a_pd = 4'b0000;    // later PD changes must not disturb the frame
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_so !== exp_bits[i]) begin errors++; $display("FAIL single_so[%0d] got %b exp %b", i, a_so, exp_bits[i]); end
      checks++; if (a_sov !== 1'b1) begin errors++; $display("FAIL single_sov[%0d] got %b exp 1", i, a_sov); end
      checks++; if (a_done !== (i == 3)) begin errors++; $display("FAIL single_done[%0d] got %b exp %b", i, a_done, (i == 3)); end
      checks++; if (a_ready !== (i == 3)) begin errors++; $display("FAIL single_ready[%0d] got %b exp %b", i, a_ready, (i == 3)); end
      tick;
    end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL single_idle_so got %b exp 0", a_so); end
    checks++; if (a_sov !== 1'b0) begin errors++; $display("FAIL single_idle_sov got %b exp 0", a_sov); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_idle_ready got %b exp 1", a_ready); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL single_idle_done got %b exp 0", a_done); end
  endtask

  task automatic test_msb_first;
    logic [3:0] exp_seq;
    exp_seq = 4'b1101;                // exp_seq[i] = SO at bit i: 1,0,1,1
    b_pd = 4'b1011; b_load = 1'b1;
    tick;
    b_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_so !== exp_seq[i]) begin errors++; $display("FAIL msb_so[%0d] got %b exp %b", i, b_so, exp_seq[i]); end
      checks++; if (b_done !== (i == 3)) begin errors++; $display("FAIL msb_done[%0d] got %b exp %b", i, b_done, (i == 3)); end
      tick;
    end
    checks++; if (b_sov !== 1'b0) begin errors++; $display("FAIL msb_idle_sov got %b exp 0", b_sov); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp_seq;
    int dones;
    exp_seq = 8'b0000_1111;           // 1,1,1,1,0,0,0,0
    dones = 0;
    a_pd = 4'b1111; a_load = 1'b1;
    tick;
    a_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++; if (a_so !== exp_seq[i]) begin errors++; $display("FAIL b2b_so[%0d] got %b exp %b", i, a_so, exp_seq[i]); end
      checks++; if (a_sov !== 1'b1) begin errors++; $display("FAIL b2b_sov[%0d] got %b exp 1", i, a_sov); end
      checks++; if (a_done !== (i == 3 || i == 7)) begin errors++; $display("FAIL b2b_done[%0d] got %b exp %b", i, a_done, (i == 3 || i == 7)); end
      if (a_done === 1'b1) dones++;
      if (i == 3) begin
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_last got %b exp 1", a_ready); end
        a_pd = 4'b0000; a_load = 1'b1;
      end
      tick;
      a_load = 1'b0;
    end
    checks++; if (dones != 2) begin errors++; $display("FAIL b2b_done_count got %0d exp 2", dones); end
    checks++; if (a_sov !== 1'b0) begin errors++; $display("FAIL b2b_idle_sov got %b exp 0", a_sov); end
  endtask

  task automatic test_busy_reject;
    logic [3:0] exp_bits;
    exp_bits = 4'b1100;               // on SO: 0,0,1,1
    a_pd = 4'b1100; a_load = 1'b1;
    tick;
    a_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_so !== exp_bits[i]) begin errors++; $display("FAIL busy_so[%0d] got %b exp %b", i, a_so, exp_bits[i]); end
      if (i == 1) begin
        a_pd = 4'b0101; a_load = 1'b1;
        #1;
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b exp 0", a_ready); end
      end
      tick;
      a_load = 1'b0;
    end
    checks++; if (a_sov !== 1'b0) begin errors++; $display("FAIL busy_idle_sov got %b exp 0", a_sov); end
    tick;
    checks++; if (a_sov !== 1'b0) begin errors++; $display("FAIL busy_no_second_sov got %b exp 0", a_sov); end
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL busy_no_second_so got %b exp 0", a_so); end
  endtask

  task automatic test_reset_midframe;
    logic [3:0] exp_bits;
    a_pd = 4'b1111; a_load = 1'b1;
    tick;
    a_load = 1'b0;
    tick;                             // 2nd bit now on SO
    checks++; if (a_so !== 1'b1) begin errors++; $display("FAIL midrst_pre_so got %b exp 1", a_so); end
    a_rst = 1'b0;
    #1;
    checks++; if (a_so !== 1'b0) begin errors++; $display("FAIL midrst_so got %b exp 0", a_so); end
    checks++; if (a_sov !== 1'b0) begin errors++; $display("FAIL midrst_sov got %b exp 0", a_sov); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", a_done); end
    tick;
    tick;
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL midrst_hold_done got %b exp 0", a_done); end
    a_rst = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got %b exp 1", a_ready); end
    exp_bits = 4'b0001;               // on SO: 1,0,0,0
    a_pd = 4'b0001; a_load = 1'b1;
    tick;
    a_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (a_so !== exp_bits[i]) begin errors++; $display("FAIL midrst_new_so[%0d] got %b exp %b", i, a_so, exp_bits[i]); end
      checks++; if (a_done !== (i == 3)) begin errors++; $display("FAIL midrst_new_done[%0d] got %b exp %b", i, a_done, (i == 3)); end
      tick;
    end
  endtask

  task automatic test_width_sweep;
    logic [7:0] exp_seq;
    exp_seq = 8'b1010_0101;           // on SO: 1,0,1,0,0,1,0,1
    c_pd = 8'hA5; c_load = 1'b1;
    tick;
    c_load = 1'b0; c_pd = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      checks++; if (c_so !== exp_seq[i]) begin errors++; $display("FAIL w8_so[%0d] got %b exp %b", i, c_so, exp_seq[i]); end
      checks++; if (c_done !== (i == 7)) begin errors++; $display("FAIL w8_done[%0d] got %b exp %b", i, c_done, (i == 7)); end
      checks++; if (u_c.cnt_q !== 3'(i)) begin errors++; $display("FAIL w8_cnt[%0d] got %0d exp %0d", i, u_c.cnt_q, i); end
      tick;
    end
    checks++; if (c_sov !== 1'b0) begin errors++; $display("FAIL w8_idle_sov got %b exp 0", c_sov); end
    checks++; if (u_c.cnt_q !== 3'd0) begin errors++; $display("FAIL w8_idle_cnt got %0d exp 0", u_c.cnt_q); end
  endtask

  initial begin
    a_rst = 1'b0; a_load = 1'b0; a_pd = '0;
    b_rst = 1'b0; b_load = 1'b0; b_pd = '0;
    c_rst = 1'b0; c_load = 1'b0; c_pd = '0;
    test_reset;
    test_single_lsb;
    test_msb_first;
    test_back_to_back;
    test_busy_reject;
    test_reset_midframe;
    test_width_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
